vram_cmd_streamer: RTL and testbench

// CPU-side end of the PPU VRAM write handshake.
// - Buffers CPU VRAM write commands in a FIFO. Writes are grouped into batches by a commit pulse.
// - On the PPU's cpu_vram_wr_irq, replays the committed batch onto the h2f_vram_* write port.
// - Holds cpu_wr_busy high while replaying, so the PPU can enter its LATE state if the replay overruns vblank.

---
 rtl/vram_cmd_streamer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_vram_cmd_streamer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cmd_streamer.sv
// vram_cmd_streamer
// CPU-side end of the PPU VRAM write handshake. CPU write commands are
// queued in a FIFO and grouped into batches by a commit pulse. When the PPU
// signals that CPU-facing VRAM may be written, the committed batch is
// replayed onto the h2f_vram_* write port one beat per cycle.
//
// Replay pipeline (irq sampled high at edge N, batch size B):
//   edge N       : FSM enters DRAIN, beat counter loaded with B
//   edges N+1..  : one FIFO pop per cycle (synchronous read into a stage reg)
//   edges N+2..  : stage register copied to the registered write port
//   edge N+2+B   : cpu_wr_busy drops once the stage has emptied
module vram_cmd_streamer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_data,
  input  logic [DATA_W/8-1:0]          cmd_byteena,
  input  logic                         cmd_commit,
  input  logic                         cpu_vram_wr_irq,
  output logic [ADDR_W-1:0]            h2f_vram_wraddr,
  output logic                         h2f_vram_wren,
  output logic [DATA_W-1:0]            h2f_vram_wrdata,
  output logic [DATA_W/8-1:0]          h2f_vram_byteena,
  output logic                         cpu_wr_busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [$clog2(DEPTH+1)-1:0]   commit_level,
  output logic                         irq_overrun,
  input  logic                         overrun_clr
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W + BE_W;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] r_ucnt;   // pushed but not yet committed
  logic [LVL_W-1:0] r_ccnt;   // committed but not yet replayed
  logic [LVL_W-1:0] r_beats;  // beats left in the batch being replayed
  logic             r_ready;

  // Replay pipeline
  logic             r_stage_vld;
  logic [ENT_W-1:0] r_stage;

  // Registered write port and status
  logic              r_wren;
  logic [ADDR_W-1:0] r_wraddr;
  logic [DATA_W-1:0] r_wrdata;
  logic [BE_W-1:0]   r_byteena;
  logic              r_busy;
  logic              r_overrun;

  // Combinational control
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_ovr_set;
  logic [LVL_W-1:0] w_push_ext;
  logic [LVL_W-1:0] w_pop_ext;
  logic [LVL_W-1:0] w_level_nxt;
  logic [LVL_W-1:0] w_ucnt_nxt;
  logic [LVL_W-1:0] w_ccnt_nxt;
  logic [LVL_W-1:0] w_beats_nxt;

  // A command transfers whenever the FIFO is not full.
  assign w_push     = cmd_valid & r_ready;
  assign w_push_ext = {{(LVL_W-1){1'b0}}, w_push};
  assign w_pop_ext  = {{(LVL_W-1){1'b0}}, w_pop};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start a replay only when something is committed; finish
  // on the pop that consumes the last beat of the latched batch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cpu_vram_wr_irq && (r_ccnt != '0)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (r_beats == ONE_LVL) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: batch load in IDLE, one pop per cycle in DRAIN, and an
  // irq seen while draining is flagged as an overrun instead of restarting.
  always_comb begin
    w_load    = 1'b0;
    w_pop     = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load    = cpu_vram_wr_irq && (r_ccnt != '0);
        w_pop     = 1'b0;
        w_ovr_set = 1'b0;
      end
      ST_DRAIN: begin
        w_load    = 1'b0;
        w_pop     = 1'b1;
        w_ovr_set = cpu_vram_wr_irq;
      end
      default: begin
        w_load    = 1'b0;
        w_pop     = 1'b0;
        w_ovr_set = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Occupancy / batch accounting
  // ---------------------------------------------------------------------

  // Next values of the level, uncommitted, committed and beat counters.
  // A commit folds every accepted entry (including a same-cycle push) into
  // the committed count; commits during DRAIN never touch the beat counter.
  always_comb begin
    w_level_nxt = r_level + w_push_ext - w_pop_ext;
    if (cmd_commit) begin
      w_ucnt_nxt = '0;
      w_ccnt_nxt = r_ccnt + r_ucnt + w_push_ext - w_pop_ext;
    end else begin
      w_ucnt_nxt = r_ucnt + w_push_ext;
      w_ccnt_nxt = r_ccnt - w_pop_ext;
    end
    if (w_load) begin
      w_beats_nxt = r_ccnt;
    end else if (w_pop) begin
      w_beats_nxt = r_beats - ONE_LVL;
    end else begin
      w_beats_nxt = r_beats;
    end
  end

  // Pointers, counters and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ucnt   <= '0;
      r_ccnt   <= '0;
      r_beats  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_level <= w_level_nxt;
      r_ucnt  <= w_ucnt_nxt;
      r_ccnt  <= w_ccnt_nxt;
      r_beats <= w_beats_nxt;
      r_ready <= (w_level_nxt != FULL_LVL);
    end
  end

  // ---------------------------------------------------------------------
  // Storage and replay pipeline
  // ---------------------------------------------------------------------

  // FIFO array write and synchronous read into the stage register; kept
  // reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_addr, cmd_data, cmd_byteena};
    end
    if (w_pop) begin
      r_stage <= r_mem[r_rd_ptr];
    end
  end

  // Stage valid flag follows the pop one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_vld <= 1'b0;
    end else begin
      r_stage_vld <= w_pop;
    end
  end

  // Registered write port: present a staged entry as one beat; otherwise
  // drop the strobe and hold the last address/data/byte enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wren    <= 1'b0;
      r_wraddr  <= '0;
      r_wrdata  <= '0;
      r_byteena <= '0;
    end else begin
      r_wren <= r_stage_vld;
      if (r_stage_vld) begin
        {r_wraddr, r_wrdata, r_byteena} <= r_stage;
      end else begin
        r_wraddr  <= r_wraddr;
        r_wrdata  <= r_wrdata;
        r_byteena <= r_byteena;
      end
    end
  end

  // Busy covers the DRAIN state plus the stage cycle that trails it, so it
  // rises one edge after the irq and falls one edge after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_DRAIN) || r_stage_vld;
    end
  end

  // Sticky overrun flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign cmd_ready        = r_ready;
  assign h2f_vram_wren    = r_wren;
  assign h2f_vram_wraddr  = r_wraddr;
  assign h2f_vram_wrdata  = r_wrdata;
  assign h2f_vram_byteena = r_byteena;
  assign cpu_wr_busy      = r_busy;
  assign fifo_level       = r_level;
  assign commit_level     = r_ccnt;
  assign irq_overrun      = r_overrun;

endmodule

// File: tb/tb_vram_cmd_streamer.sv
// Directed self-checking bench for vram_cmd_streamer.
module tb_vram_cmd_streamer;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int LVL_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [BE_W-1:0]   cmd_byteena = '0;
  logic              cmd_commit = 1'b0;
  logic              cpu_vram_wr_irq = 1'b0;
  logic [ADDR_W-1:0] wraddr;
  logic              wren;
  logic [DATA_W-1:0] wrdata;
  logic [BE_W-1:0]   byteena;
  logic              busy;
  logic [LVL_W-1:0]  fifo_level;
  logic [LVL_W-1:0]  commit_level;
  logic              irq_overrun;
  logic              overrun_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] q_addr [$];

  logic [DATA_W-1:0] bd [3] = '{64'h1111_2222_3333_4444, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF};
  logic [BE_W-1:0]   bb [3] = '{8'h0F, 8'hFF, 8'h81};

  vram_cmd_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_byteena(cmd_byteena), .cmd_commit(cmd_commit),
    .cpu_vram_wr_irq(cpu_vram_wr_irq),
    .h2f_vram_wraddr(wraddr), .h2f_vram_wren(wren), .h2f_vram_wrdata(wrdata),
    .h2f_vram_byteena(byteena), .cpu_wr_busy(busy),
    .fifo_level(fifo_level), .commit_level(commit_level),
    .irq_overrun(irq_overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [BE_W-1:0] be, input logic commit);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_byteena = be; cmd_commit = commit;
    tick;
    cmd_valid = 1'b0; cmd_commit = 1'b0;
  endtask

  task automatic pulse_commit;
    cmd_commit = 1'b1;
    tick;
    cmd_commit = 1'b0;
  endtask

  task automatic pulse_irq;
    cpu_vram_wr_irq = 1'b1;
    tick;
    cpu_vram_wr_irq = 1'b0;
  endtask

  // Records beats until busy falls (after having been seen high) or the budget runs out.
  task automatic collect_beats(input logic start_seen, input int max_cyc, output int n, output logic timeout);
    logic seen;
    seen = start_seen;
    n = 0;
    timeout = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      tick;
      if (wren) begin
        n++;
        q_addr.push_back(wraddr);
      end
      if (busy) seen = 1'b1;
      else if (seen) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", cmd_ready); end
    total++; if (wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%0b want=0", wren); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (fifo_level !== 9'd0 || commit_level !== 9'd0) begin bad++; $display("FAIL reset_levels got=%0d/%0d want=0/0", fifo_level, commit_level); end
    total++; if (irq_overrun !== 1'b0 || wraddr !== 13'd0 || wrdata !== 64'd0 || byteena !== 8'd0) begin bad++; $display("FAIL reset_outs ovr=%0b addr=%h data=%h be=%h want all 0", irq_overrun, wraddr, wrdata, byteena); end
  endtask

  task automatic test_basic;
    logic exp_busy, exp_wren;
    for (int i = 0; i < 3; i++) drive_push(13'h10 + 13'(i), bd[i], bb[i], 1'b0);
    pulse_commit;
    total++; if (commit_level !== 9'd3 || fifo_level !== 9'd3) begin bad++; $display("FAIL basic_levels got=%0d/%0d want=3/3", commit_level, fifo_level); end
    pulse_irq;  // now just after edge N
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_N got=%0b want=0", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick;
      exp_busy = (k <= 4);
      exp_wren = (k >= 2 && k <= 4);
      total++; if (busy !== exp_busy || wren !== exp_wren) begin bad++; $display("FAIL basic_timing edge N+%0d busy=%0b wren=%0b want %0b %0b", k, busy, wren, exp_busy, exp_wren); end
      if (k >= 2 && k <= 4) begin
        total++; if (wraddr !== 13'h10 + 13'(k-2) || wrdata !== bd[k-2] || byteena !== bb[k-2]) begin bad++; $display("FAIL basic_beat%0d addr=%h data=%h be=%h want %h %h %h", k-2, wraddr, wrdata, byteena, 13'h10 + 13'(k-2), bd[k-2], bb[k-2]); end
      end
    end
    total++; if (wraddr !== 13'h12 || wrdata !== bd[2] || byteena !== bb[2]) begin bad++; $display("FAIL basic_hold addr=%h data=%h be=%h", wraddr, wrdata, byteena); end
    total++; if (fifo_level !== 9'd0 || commit_level !== 9'd0) begin bad++; $display("FAIL basic_after got=%0d/%0d want=0/0", fifo_level, commit_level); end
  endtask

  task automatic test_irq_no_commit;
    logic any_busy, any_wren;
    int n; logic to;
    pulse_irq;
    any_busy = 1'b0; any_wren = 1'b0;
    repeat (4) begin tick; any_busy |= busy; any_wren |= wren; end
    total++; if (any_busy || any_wren) begin bad++; $display("FAIL empty_irq busy=%0b wren=%0b want 0 0", any_busy, any_wren); end
    for (int i = 0; i < 4; i++) drive_push(13'h20 + 13'(i), 64'(i), 8'hFF, 1'b0);
    pulse_irq;
    any_busy = 1'b0; any_wren = 1'b0;
    repeat (4) begin tick; any_busy |= busy; any_wren |= wren; end
    total++; if (any_busy || any_wren) begin bad++; $display("FAIL uncommitted_irq busy=%0b wren=%0b want 0 0", any_busy, any_wren); end
    total++; if (fifo_level !== 9'd4 || commit_level !== 9'd0) begin bad++; $display("FAIL uncommitted_levels got=%0d/%0d want=4/0", fifo_level, commit_level); end
    pulse_commit;
    pulse_irq;
    q_addr.delete();
    collect_beats(1'b0, 20, n, to);
    total++; if (to || n != 4 || q_addr.size() != 4 || q_addr[3] !== 13'h23) begin bad++; $display("FAIL uncommitted_drain beats=%0d timeout=%0b want 4 0", n, to); end
  endtask

  task automatic test_partial_commit;
    int n; logic to;
    for (int i = 0; i < 5; i++) drive_push(13'h30 + 13'(i), 64'(i), 8'h01, (i == 1));
    total++; if (commit_level !== 9'd2 || fifo_level !== 9'd5) begin bad++; $display("FAIL partial_levels got=%0d/%0d want=2/5", commit_level, fifo_level); end
    pulse_irq;
    q_addr.delete();
    collect_beats(1'b0, 20, n, to);
    total++; if (to || n != 2 || q_addr.size() != 2 || q_addr[0] !== 13'h30 || q_addr[1] !== 13'h31) begin bad++; $display("FAIL partial_beats beats=%0d timeout=%0b want 2 0", n, to); end
    total++; if (commit_level !== 9'd0 || fifo_level !== 9'd3) begin bad++; $display("FAIL partial_after got=%0d/%0d want=0/3", commit_level, fifo_level); end
    pulse_commit;
    pulse_irq;
    q_addr.delete();
    collect_beats(1'b0, 20, n, to);
    total++; if (to || n != 3 || q_addr.size() != 3 || q_addr[2] !== 13'h34) begin bad++; $display("FAIL partial_rest beats=%0d timeout=%0b want 3 0", n, to); end
  endtask

  task automatic test_full;
    int n; logic to;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        total++; if (cmd_ready !== 1'b1 || fifo_level !== 9'd255) begin bad++; $display("FAIL full_255 ready=%0b level=%0d want 1 255", cmd_ready, fifo_level); end
      end
      drive_push(13'(i), 64'(i), 8'hAA, 1'b0);
    end
    total++; if (cmd_ready !== 1'b0 || fifo_level !== 9'd256) begin bad++; $display("FAIL full_256 ready=%0b level=%0d want 0 256", cmd_ready, fifo_level); end
    drive_push(13'h1FFF, 64'hBAD, 8'hFF, 1'b0);
    total++; if (fifo_level !== 9'd256) begin bad++; $display("FAIL full_reject level=%0d want 256", fifo_level); end
    pulse_commit;
    total++; if (commit_level !== 9'd256) begin bad++; $display("FAIL full_commit got=%0d want 256", commit_level); end
    pulse_irq;
    tick;  // N+1: first pop
    total++; if (fifo_level !== 9'd255 || cmd_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL full_pop1 level=%0d ready=%0b busy=%0b want 255 1 1", fifo_level, cmd_ready, busy); end
    drive_push(13'h1ABC, 64'hCAFE, 8'h3C, 1'b0);  // N+2: push and pop together
    total++; if (fifo_level !== 9'd255 || wren !== 1'b1 || wraddr !== 13'h000) begin bad++; $display("FAIL full_pushpop level=%0d wren=%0b addr=%h want 255 1 000", fifo_level, wren, wraddr); end
    q_addr.delete();
    collect_beats(1'b1, 400, n, to);
    total++; if (to || n != 255 || q_addr.size() != 255 || q_addr[254] !== 13'h0FF) begin bad++; $display("FAIL full_drain beats=%0d timeout=%0b want 255 0", n, to); end
    total++; if (fifo_level !== 9'd1 || commit_level !== 9'd0) begin bad++; $display("FAIL full_after got=%0d/%0d want=1/0", fifo_level, commit_level); end
    pulse_commit;
    pulse_irq;
    q_addr.delete();
    collect_beats(1'b0, 20, n, to);
    total++; if (to || n != 1 || q_addr.size() != 1 || q_addr[0] !== 13'h1ABC || wrdata !== 64'hCAFE || byteena !== 8'h3C) begin bad++; $display("FAIL full_extra beats=%0d data=%h be=%h want 1 cafe 3c", n, wrdata, byteena); end
  endtask

  task automatic test_overrun;
    int n; logic to; logic any_wren;
    for (int i = 0; i < 10; i++) drive_push(13'h40 + 13'(i), 64'(i), 8'hFF, (i == 9));
    pulse_irq;
    tick;
    tick;  // N+2: first beat
    cpu_vram_wr_irq = 1'b1; overrun_clr = 1'b1;
    tick;  // N+3: second beat, irq sampled during DRAIN
    cpu_vram_wr_irq = 1'b0; overrun_clr = 1'b0;
    total++; if (irq_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b want 1", irq_overrun); end
    q_addr.delete();
    collect_beats(1'b1, 40, n, to);
    total++; if (to || n != 8 || q_addr.size() != 8 || q_addr[7] !== 13'h49) begin bad++; $display("FAIL ovr_beats rest=%0d timeout=%0b want 8 0", n, to); end
    any_wren = 1'b0;
    repeat (3) begin tick; any_wren |= wren; end
    total++; if (any_wren || irq_overrun !== 1'b1 || fifo_level !== 9'd0) begin bad++; $display("FAIL ovr_after wren=%0b ovr=%0b level=%0d want 0 1 0", any_wren, irq_overrun, fifo_level); end
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    total++; if (irq_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%0b want 0", irq_overrun); end
  endtask

  task automatic test_commit_during_drain;
    int n; logic to;
    for (int i = 0; i < 8; i++) drive_push(13'h50 + 13'(i), 64'(i), 8'hFF, (i == 7));
    pulse_irq;
    tick;
    drive_push(13'h60, 64'h60, 8'h11, 1'b0);
    drive_push(13'h61, 64'h61, 8'h22, 1'b1);
    q_addr.delete();
    collect_beats(1'b1, 40, n, to);
    total++; if (to || n != 6 || q_addr.size() != 6 || q_addr[5] !== 13'h57) begin bad++; $display("FAIL cdd_beats rest=%0d timeout=%0b want 6 0", n, to); end
    total++; if (commit_level !== 9'd2 || fifo_level !== 9'd2) begin bad++; $display("FAIL cdd_levels got=%0d/%0d want=2/2", commit_level, fifo_level); end
    pulse_irq;
    q_addr.delete();
    collect_beats(1'b0, 20, n, to);
    total++; if (to || n != 2 || q_addr.size() != 2 || q_addr[0] !== 13'h60 || q_addr[1] !== 13'h61) begin bad++; $display("FAIL cdd_next beats=%0d timeout=%0b want 2 0", n, to); end
  endtask

  task automatic test_reset_mid_drain;
    logic any_act;
    for (int i = 0; i < 8; i++) drive_push(13'h70 + 13'(i), 64'(i), 8'hFF, (i == 7));
    pulse_irq;
    repeat (4) tick;  // N+4: third beat
    total++; if (wren !== 1'b1 || wraddr !== 13'h72) begin bad++; $display("FAIL rst_pre wren=%0b addr=%h want 1 072", wren, wraddr); end
    rst_n = 1'b0;
    #1;
    total++; if (wren !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid wren=%0b busy=%0b want 0 0", wren, busy); end
    total++; if (fifo_level !== 9'd0 || commit_level !== 9'd0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_levels %0d/%0d ready=%0b want 0/0 1", fifo_level, commit_level, cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    any_act = 1'b0;
    repeat (5) begin tick; any_act |= wren | busy; end
    total++; if (any_act) begin bad++; $display("FAIL rst_after activity=%0b want 0", any_act); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_irq_no_commit;
    test_partial_commit;
    test_full;
    test_overrun;
    test_commit_during_drain;
    test_reset_mid_drain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
